// File: rtl/reg_file.sv
// Register file: two combinational read ports, one write port, plus dirty flags and a write counter; REG_FILE_BYPASS_EN selects write-first reads on collision.
// Zero-cycle reads, writes commit on the rising CLK edge; no backpressure, every WRITE with RESET high commits.
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [DATA_WIDTH-1:0]        IN,
  input  logic [ADDR_WIDTH-1:0]        INADDRESS,
  input  logic                         WRITE,
  input  logic [ADDR_WIDTH-1:0]        OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0]        OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0]        REGOUT1,
  output logic [DATA_WIDTH-1:0]        REGOUT2,
  output logic [(1<<ADDR_WIDTH)-1:0]   DIRTY,
  output logic [7:0]                   WRCOUNT
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]                 dirty_q, dirty_d;
  logic [7:0]                       wrcount_q, wrcount_d;

  always_comb begin
    regs_d    = regs_q;
    dirty_d   = dirty_q;
    wrcount_d = wrcount_q;
    if (WRITE) begin
      regs_d[INADDRESS]  = IN;
      dirty_d[INADDRESS] = 1'b1;
      wrcount_d          = wrcount_q + 8'd1;
    end
  end

  // Reset holds the array at zero, which also forces the read ports to zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regs_q    <= '0;
      dirty_q   <= '0;
      wrcount_q <= '0;
    end else begin
      regs_q    <= regs_d;
      dirty_q   <= dirty_d;
      wrcount_q <= wrcount_d;
    end
  end

  always_comb begin
    REGOUT1 = regs_q[OUT1ADDRESS];
    REGOUT2 = regs_q[OUT2ADDRESS];
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && RESET && (OUT1ADDRESS == INADDRESS)) REGOUT1 = IN;
    if (WRITE && RESET && (OUT2ADDRESS == INADDRESS)) REGOUT2 = IN;
`endif
  end

  assign DIRTY   = dirty_q;
  assign WRCOUNT = wrcount_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded bench for reg_file: driver pushes model expectations, monitor samples the DUT and compares.
module tb_reg_file;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] regout1, regout2, dirty, wrcount;

  reg_file dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .REGOUT1(regout1), .REGOUT2(regout2), .DIRTY(dirty), .WRCOUNT(wrcount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] dirty;
    logic [7:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  event  sample_ev;
  int    checks = 0;
  int    passes = 0;

  // Reference model: plain array plus a set of written addresses and a mod-256 count.
  logic [7:0] model [8];
  logic [7:0] mdirty;
  logic [7:0] mcount;

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    mdirty = 8'h00;
    mcount = 8'h00;
  endfunction

  function automatic logic [7:0] mread(input logic [2:0] a);
    if (!RESET) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && a == INADDRESS) return IN;
`endif
    return model[a];
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s.%s actual=0x%02h expected=0x%02h", nm, fld, act, expv);
  endtask

  // Monitor: decoupled from the driver, samples 1 time unit after each request.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        cmp(n, "regout1", regout1, e.r1);
        cmp(n, "regout2", regout2, e.r2);
        cmp(n, "dirty",   dirty,   e.dirty);
        cmp(n, "wrcount", wrcount, e.cnt);
      end
    end
  end

  task automatic chk(input string nm);
    exp_t e;
    e.r1    = mread(OUT1ADDRESS);
    e.r2    = mread(OUT2ADDRESS);
    e.dirty = RESET ? mdirty : 8'h00;
    e.cnt   = RESET ? mcount : 8'h00;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    -> sample_ev;
    #2;
  endtask

  task automatic chk_at(input logic [2:0] o1, input logic [2:0] o2, input string nm);
    @(negedge CLK);
    OUT1ADDRESS = o1;
    OUT2ADDRESS = o2;
    chk(nm);
  endtask

  // One clock cycle: drive, check pre-edge (collision view), commit at the edge.
  task automatic cyc(input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic [2:0] o1, input logic [2:0] o2, input string nm);
    @(negedge CLK);
    WRITE = w; INADDRESS = a; IN = d; OUT1ADDRESS = o1; OUT2ADDRESS = o2;
    chk(nm);
    @(posedge CLK);
    if (RESET && w) begin
      model[a]  = d;
      mdirty[a] = 1'b1;
      mcount    = mcount + 8'd1;
    end
    #1 WRITE = 1'b0;
  endtask

  task automatic async_reset(input string nm);
    @(negedge CLK);
    #1 RESET = 1'b0;
    model_clear();
    chk(nm);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] last;
    RESET = 1'b1; WRITE = 1'b0; IN = 8'h00; INADDRESS = 3'd0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    model_clear();
    #3 RESET = 1'b0;
    chk("reset_initial");
    @(negedge CLK);
    RESET = 1'b1;

    // Write and dual read
    cyc(1'b1, 3'd3, 8'h5A, 3'd3, 3'd7, "wr_r3");
    cyc(1'b1, 3'd7, 8'hC3, 3'd3, 3'd7, "wr_r7");
    chk_at(3'd3, 3'd7, "dual_read");
    chk_at(3'd7, 3'd7, "same_addr");

    // Collision: bypass decides the pre-edge value
    cyc(1'b1, 3'd2, 8'h11, 3'd0, 3'd0, "wr_r2");
    cyc(1'b1, 3'd2, 8'h22, 3'd2, 3'd3, "collide_pre");
    chk_at(3'd2, 3'd2, "collide_post");

    // ALU hookup: SELECT 3'b011 is OR, result written back to r4
    cyc(1'b1, 3'd1, 8'h0F, 3'd1, 3'd2, "alu_r1");
    cyc(1'b1, 3'd2, 8'hF0, 3'd1, 3'd2, "alu_r2");
    cyc(1'b1, 3'd4, model[1] | model[2], 3'd4, 3'd1, "alu_wb");
    chk_at(3'd4, 3'd2, "alu_r4");

    // Asynchronous reset mid-cycle, no clock edge before sampling
    async_reset("reset_async");
    chk_at(3'd3, 3'd7, "after_reset");

    // Reset pulsed while a write to r5 is pending
    cyc(1'b1, 3'd6, 8'h44, 3'd6, 3'd0, "pre_r6");
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'hFF; INADDRESS = 3'd5; OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd6;
    chk("rst_pending_pre");
    RESET = 1'b0;
    model_clear();
    chk("rst_pending_low");
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1; WRITE = 1'b0;
    chk_at(3'd5, 3'd6, "rst_r5_cleared");
    cyc(1'b1, 3'd5, 8'h33, 3'd5, 3'd0, "first_after_rst");
    chk_at(3'd5, 3'd0, "first_after_rst_post");

    // Counter wrap: 256 writes to r0
    async_reset("reset_for_wrap");
    last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      last = 8'($urandom);
      cyc(1'b1, 3'd0, last, 3'd0, 3'($urandom_range(0, 7)), "wrap");
    end
    chk_at(3'd0, 3'd1, "wrap_end");

    // Randomized traffic, including WRITE=0 hold cycles and collisions
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom), 3'($urandom), 8'($urandom),
          3'($urandom), 3'($urandom), "random");
    end
    chk_at(3'($urandom), 3'($urandom), "random_end");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    #5;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
